// File: rtl/gpio_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_ctrl_pkg
//  Purpose  : Shared encodings for the GPIO write arbiter slice.
//             - op_t    : read-modify-write op codes (WRITE/SET/CLEAR/TOGGLE)
//             - state_t : arbiter FSM states (IDLE/APPLY)
//             - GPIO_ADDR_DEFAULT : bus address that selects the GPIO register
//  Revision : 1.0 - initial release
// ============================================================================
package gpio_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_t;

  localparam logic [31:0] GPIO_ADDR_DEFAULT = 32'h0000ABCD;

endpackage : gpio_ctrl_pkg
`default_nettype wire

// File: rtl/gpio_op_unit.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_op_unit
//  Purpose  : Combinational next-value function for the GPIO register.
//             Applies a bitwise op to the current value, then keeps the old
//             value in every byte whose enable bit is low.
//  Ports    : cur_val  [WIDTH]   current GPIO register value
//             operand  [WIDTH]   latched write data
//             op       op_t      WRITE / SET / CLEAR / TOGGLE
//             byte_en  [WIDTH/8] per-byte update enable (all ones = full word)
//             next_val [WIDTH]   value to load into the register
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_op_unit
  import gpio_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   cur_val,
  input  logic [WIDTH-1:0]   operand,
  input  op_t                op,
  input  logic [WIDTH/8-1:0] byte_en,
  output logic [WIDTH-1:0]   next_val
);

  localparam int NBYTES = WIDTH / 8;

  logic [WIDTH-1:0] op_result;

  always_comb begin
    op_result = cur_val;
    case (op)
      OP_WRITE:  op_result = operand;
      OP_SET:    op_result = cur_val | operand;
      OP_CLEAR:  op_result = cur_val & ~operand;
      OP_TOGGLE: op_result = cur_val ^ operand;
      default:   op_result = cur_val;
    endcase
  end

  // Byte lanes with a cleared enable keep their previous contents.
  generate
    for (genvar b = 0; b < NBYTES; b++) begin : g_byte
      assign next_val[b*8 +: 8] = byte_en[b] ? op_result[b*8 +: 8] : cur_val[b*8 +: 8];
    end
  endgenerate

endmodule : gpio_op_unit
`default_nettype wire

// File: rtl/gpio_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_write_arbiter
//  Purpose  : Shares the GPIO output register between two requesters
//             (port 0 = CPU store path, port 1 = debug/loader path).
//             Each request is an addressed read-modify-write op with a
//             req/ack handshake; a request sampled in IDLE at cycle N shows
//             its ack and gpio_out update in cycle N+2.
//  Ports    : clock, reset         system clock, synchronous active-high reset
//             reqN/addrN/wdataN/opN request, target address, operand, op code
//             ackN                 one-cycle completion pulse
//             gpio_out             GPIO register (drives the pins)
//             busy                 high while the FSM is not IDLE
//             err                  pulses with ack when address != GPIO_ADDR
//  Options  : GPIO_BYTE_MASK_EN    adds be0/be1 byte enables (WIDTH/8 bits)
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_write_arbiter
  import gpio_ctrl_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] GPIO_ADDR = GPIO_ADDR_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0,
  input  logic [WIDTH-1:0]   addr0,
  input  logic [WIDTH-1:0]   wdata0,
  input  logic [1:0]         op0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   addr1,
  input  logic [WIDTH-1:0]   wdata1,
  input  logic [1:0]         op1,
`ifdef GPIO_BYTE_MASK_EN
  input  logic [WIDTH/8-1:0] be0,
  input  logic [WIDTH/8-1:0] be1,
`endif
  output logic               ack0,
  output logic               ack1,
  output logic [WIDTH-1:0]   gpio_out,
  output logic               busy,
  output logic               err
);

  localparam int NBYTES = WIDTH / 8;

  state_t             state_q, state_d;
  logic               grant_q, grant_d;     // latched winner: 0 = port 0, 1 = port 1
  logic               rr_ptr_q, rr_ptr_d;   // last granted port; the other wins a tie
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  op_t                op_q, op_d;
  logic [NBYTES-1:0]  be_q, be_d;
  logic [WIDTH-1:0]   gpio_q, gpio_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               err_q, err_d;

  logic               elig0, elig1;
  logic [NBYTES-1:0]  be0_in, be1_in;
  logic [WIDTH-1:0]   gpio_next;

`ifdef GPIO_BYTE_MASK_EN
  assign be0_in = be0;
  assign be1_in = be1;
`else
  assign be0_in = '1;
  assign be1_in = '1;
`endif

  gpio_op_unit #(
    .WIDTH (WIDTH)
  ) u_op_unit (
    .cur_val  (gpio_q),
    .operand  (wdata_q),
    .op       (op_q),
    .byte_en  (be_q),
    .next_val (gpio_next)
  );

  // A port whose ack is showing this cycle is not eligible; a still-high
  // req is picked up again on the following cycle.
  assign elig0 = req0 & ~ack0_q;
  assign elig1 = req1 & ~ack1_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    op_d     = op_q;
    be_d     = be_q;
    gpio_d   = gpio_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (elig0 | elig1) begin
          grant_d  = (elig0 & elig1) ? ~rr_ptr_q : elig1;
          rr_ptr_d = grant_d;
          if (grant_d) begin
            addr_d  = addr1;
            wdata_d = wdata1;
            op_d    = op_t'(op1);
            be_d    = be1_in;
          end else begin
            addr_d  = addr0;
            wdata_d = wdata0;
            op_d    = op_t'(op0);
            be_d    = be0_in;
          end
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (addr_q == GPIO_ADDR) begin
          gpio_d = gpio_next;
        end else begin
          err_d = 1'b1;
        end
        ack0_d  = ~grant_q;
        ack1_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Synchronous reset wins over an in-flight APPLY, aborting the op.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_q     <= OP_WRITE;
      be_q     <= '0;
      gpio_q   <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      op_q     <= op_d;
      be_q     <= be_d;
      gpio_q   <= gpio_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err_q    <= err_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign err      = err_q;
  assign gpio_out = gpio_q;
  assign busy     = (state_q != ST_IDLE);

endmodule : gpio_write_arbiter
`default_nettype wire

// File: tb/tb_gpio_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpio_write_arbiter
//  Purpose  : Directed self-checking bench for gpio_write_arbiter.
//             Inputs change 1 time unit after posedge; outputs are sampled
//             1 time unit after posedge.
//  Options  : GPIO_BYTE_MASK_EN    also exercises the byte-enable ports
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_write_arbiter;

  localparam logic [1:0]  C_WR  = 2'b00;
  localparam logic [1:0]  C_SET = 2'b01;
  localparam logic [1:0]  C_CLR = 2'b10;
  localparam logic [1:0]  C_TGL = 2'b11;
  localparam logic [31:0] C_GA  = 32'h0000ABCD;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [1:0]  op0 = '0, op1 = '0;
  logic [3:0]  be0 = 4'hF, be1 = 4'hF;
  logic        ack0, ack1, busy, err;
  logic [31:0] gpio_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  gpio_write_arbiter #(.WIDTH(32), .GPIO_ADDR(32'h0000ABCD)) dut (
    .clock    (clock),
    .reset    (reset),
    .req0     (req0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .op0      (op0),
    .req1     (req1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .op1      (op1),
`ifdef GPIO_BYTE_MASK_EN
    .be0      (be0),
    .be1      (be1),
`endif
    .ack0     (ack0),
    .ack1     (ack1),
    .gpio_out (gpio_out),
    .busy     (busy),
    .err      (err)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_checks++;
    if ({ack0, ack1, err, busy, gpio_out} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_state: ack0=%b ack1=%b err=%b busy=%b gpio=%h, need all 0",
               ack0, ack1, err, busy, gpio_out);
    end
  endtask

  // One port-0 op at a given address; checks latency and the resulting value.
  task automatic port0_op(input string nm, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] o, input logic [31:0] exp_gpio, input logic exp_err);
    req0 = 1'b1; addr0 = a; wdata0 = d; op0 = o;
    step();                          // APPLY cycle (N+1)
    addr0 = 32'hFFFF_FFFF; wdata0 = 32'h0BAD_0BAD; op0 = C_TGL;  // latched, so free to change
    n_checks++;
    if (ack0 !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_apply: ack0=%b busy=%b, need ack0=0 busy=1", nm, ack0, busy);
    end
    step();                          // ack cycle (N+2)
    n_checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0 || err !== exp_err || gpio_out !== exp_gpio) begin
      n_fail++;
      $display("FAIL %s_ack: ack0=%b ack1=%b err=%b gpio=%h, need 1 0 %b %h",
               nm, ack0, ack1, err, gpio_out, exp_err, exp_gpio);
    end
    req0 = 1'b0;
    step();
    n_checks++;
    if (ack0 !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || gpio_out !== exp_gpio) begin
      n_fail++;
      $display("FAIL %s_after: ack0=%b err=%b busy=%b gpio=%h, need 0 0 0 %h",
               nm, ack0, err, busy, gpio_out, exp_gpio);
    end
  endtask

  task automatic test_ops();
    port0_op("write", C_GA, 32'h0000_00FF, C_WR,  32'h0000_00FF, 1'b0);
    port0_op("set",   C_GA, 32'h0000_FF00, C_SET, 32'h0000_FFFF, 1'b0);
    port0_op("clear", C_GA, 32'h0000_000F, C_CLR, 32'h0000_FFF0, 1'b0);
    port0_op("tgl",   C_GA, 32'hFFFF_FFFF, C_TGL, 32'hFFFF_000F, 1'b0);
  endtask

  // req held through its own ack cycle: ignored there, re-granted a cycle later.
  task automatic test_back_to_back();
    req0 = 1'b1; addr0 = C_GA; wdata0 = 32'h0000_FFFF; op0 = C_TGL;
    step();
    step();
    n_checks++;
    if (ack0 !== 1'b1 || gpio_out !== 32'hFFFF_FFF0) begin
      n_fail++;
      $display("FAIL b2b_first: ack0=%b gpio=%h, need 1 fffffff0", ack0, gpio_out);
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || ack0 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ignored: busy=%b ack0=%b, need 0 0", busy, ack0);
    end
    step();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_regrant: busy=%b, need 1", busy);
    end
    step();
    n_checks++;
    if (ack0 !== 1'b1 || gpio_out !== 32'hFFFF_000F) begin
      n_fail++;
      $display("FAIL b2b_second: ack0=%b gpio=%h, need 1 ffff000f", ack0, gpio_out);
    end
    req0 = 1'b0;
    step();
  endtask

  task automatic test_arbitration();
    test_reset();
    req0 = 1'b1; addr0 = C_GA; wdata0 = 32'hA5A5_A5A5; op0 = C_WR;
    req1 = 1'b1; addr1 = C_GA; wdata1 = 32'h5A5A_5A5A; op1 = C_WR;
    step();
    step();
    n_checks++;
    if (ack1 !== 1'b1 || ack0 !== 1'b0 || gpio_out !== 32'h5A5A_5A5A) begin
      n_fail++;
      $display("FAIL arb_port1_first: ack1=%b ack0=%b gpio=%h, need 1 0 5a5a5a5a",
               ack1, ack0, gpio_out);
    end
    req1 = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b1 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_port0_apply: busy=%b ack0=%b ack1=%b, need 1 0 0", busy, ack0, ack1);
    end
    step();
    n_checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0 || gpio_out !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL arb_port0_second: ack0=%b ack1=%b gpio=%h, need 1 0 a5a5a5a5",
               ack0, ack1, gpio_out);
    end
    req0 = 1'b0;
    step();
  endtask

  task automatic test_bad_addr();
    port0_op("badaddr", 32'h0000_ABCC, 32'h1234_5678, C_WR, 32'hA5A5_A5A5, 1'b1);
  endtask

  task automatic test_reset_in_apply();
    req0 = 1'b1; addr0 = C_GA; wdata0 = 32'hDEAD_BEEF; op0 = C_WR;
    step();                          // APPLY
    reset = 1'b1;
    req0  = 1'b0;
    step();
    reset = 1'b0;
    n_checks++;
    if (ack0 !== 1'b0 || gpio_out !== 32'd0 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_apply: ack0=%b gpio=%h busy=%b err=%b, need 0 0 0 0",
               ack0, gpio_out, busy, err);
    end
    step();
    n_checks++;
    if (ack0 !== 1'b0 || gpio_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_no_late_ack: ack0=%b gpio=%h, need 0 0", ack0, gpio_out);
    end
  endtask

`ifdef GPIO_BYTE_MASK_EN
  task automatic test_byte_mask();
    be0 = 4'b1111;
    port0_op("be_full", C_GA, 32'h1122_3344, C_WR, 32'h1122_3344, 1'b0);
    be0 = 4'b0101;
    port0_op("be_0101", C_GA, 32'hAABB_CCDD, C_WR, 32'h11BB_33DD, 1'b0);
    be0 = 4'b0000;
    port0_op("be_none", C_GA, 32'hFFFF_FFFF, C_TGL, 32'h11BB_33DD, 1'b0);
    be0 = 4'b1111;
  endtask
`endif

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_arbitration();
    test_bad_addr();
    test_reset_in_apply();
`ifdef GPIO_BYTE_MASK_EN
    test_byte_mask();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_gpio_write_arbiter
`default_nettype wire
